// File: rtl/fifo_arb_pkg.sv
// Shared constants and read-side FSM encoding for the fifo_arbiter slice.
package fifo_arb_pkg;

    localparam int unsigned ENTRY_WIDTH_DEF = 32;
    localparam int unsigned DATA_MSB        = 31;
    localparam int unsigned DATA_LSB        = 16;
    localparam int unsigned LT_MSB          = 15;
    localparam int unsigned LT_LSB          = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HOLD
    } rd_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request found
// searching upward (with wrap) from ptr.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = PTR_W'((32'(ptr) + off) % NUM_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_arbiter.sv
// Round-robin writer into a shared event FIFO plus a read-side unloader FSM.
// Optional macro LT_GATE_EN holds the output entry until its lt field <= cur_time.
module fifo_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ENTRY_WIDTH = ENTRY_WIDTH_DEF,
    localparam int unsigned GW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*ENTRY_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [GW-1:0]                  grant_id,
    output logic                           fifo_enqueue,
    output logic [ENTRY_WIDTH-1:0]         fifo_data_in,
    input  logic                           fifo_full,
    output logic                           fifo_dequeue,
    input  logic [ENTRY_WIDTH-1:0]         fifo_data_out,
    input  logic                           fifo_empty,
    output logic                           out_valid,
    output logic [ENTRY_WIDTH-1:0]         out_data,
    input  logic                           out_ready,
    input  logic [15:0]                    cur_time
);

    logic [GW-1:0]      rr_ptr;
    logic [NUM_REQ-1:0] grant;
    logic [GW-1:0]      grant_idx;
    rd_state_e          state;
    logic               lt_ok;
    logic               xfer;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (GW)
    ) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    always_comb begin
        req_ready    = (reset && !fifo_full) ? grant : '0;
        fifo_enqueue = |req_ready;
        grant_idx    = '0;
        fifo_data_in = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                grant_idx    = GW'(i);
                fifo_data_in = req_data[i*ENTRY_WIDTH +: ENTRY_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr   <= '0;
            grant_id <= '0;
        end else if (fifo_enqueue) begin
            grant_id <= grant_idx;
            rr_ptr   <= (grant_idx == GW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

`ifdef LT_GATE_EN
    assign lt_ok = (out_data[LT_MSB:LT_LSB] <= cur_time);
`else
    logic unused_cur_time;
    assign unused_cur_time = ^cur_time;
    assign lt_ok           = 1'b1;
`endif

    assign out_valid = (state == ST_HOLD) && lt_ok;
    assign xfer      = out_valid && out_ready;

    // Dequeue is combinational so a HOLD transfer can re-arm the read in the
    // same cycle, giving one entry every two cycles.
    assign fifo_dequeue = reset && !fifo_empty &&
                          ((state == ST_IDLE) || (state == ST_HOLD && xfer));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            out_data <= '0;
        end else begin
            case (state)
                ST_IDLE: if (!fifo_empty) state <= ST_WAIT;
                ST_WAIT: begin
                    out_data <= fifo_data_out;
                    state    <= ST_HOLD;
                end
                ST_HOLD: if (xfer) state <= fifo_empty ? ST_IDLE : ST_WAIT;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_arbiter.sv
// Scoreboard bench for fifo_arbiter with a behavioural FIFO model on both ports.
module tb_fifo_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic [1:0]   grant_id;
    logic         fifo_enqueue;
    logic [31:0]  fifo_data_in;
    logic         fifo_full;
    logic         fifo_dequeue;
    logic [31:0]  fifo_data_out = '0;
    logic         fifo_empty = 1'b1;
    logic         out_valid;
    logic [31:0]  out_data;
    logic         out_ready;
    logic [15:0]  cur_time;

    logic         force_full;
    logic         mfull = 1'b0;
    logic         pre_req;
    logic [31:0]  pre_data;

    typedef struct {
        int unsigned id;
        logic [31:0] data;
    } enq_t;

    enq_t        exp_enq[$];
    logic [31:0] exp_out[$];
    logic [31:0] mq[$];
    int unsigned xfer_cyc[$];
    int unsigned cyc = 0;
    int unsigned exp_gid = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    assign fifo_full = force_full | mfull;

    always #5 clk = ~clk;

    fifo_arbiter #(
        .NUM_REQ     (4),
        .ENTRY_WIDTH (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .grant_id      (grant_id),
        .fifo_enqueue  (fifo_enqueue),
        .fifo_data_in  (fifo_data_in),
        .fifo_full     (fifo_full),
        .fifo_dequeue  (fifo_dequeue),
        .fifo_data_out (fifo_data_out),
        .fifo_empty    (fifo_empty),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_ready     (out_ready),
        .cur_time      (cur_time)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural FIFO: read data appears the cycle after a sampled dequeue.
    always @(posedge clk) begin
        if (fifo_dequeue && mq.size() > 0) fifo_data_out <= mq.pop_front();
        if (fifo_enqueue) mq.push_back(fifo_data_in);
        if (pre_req) mq.push_back(pre_data);
        fifo_empty <= (mq.size() == 0);
        mfull      <= (mq.size() >= 8);
    end

    always @(negedge clk) begin : wr_mon
        enq_t e;
        if (!reset) exp_gid = 0;
        check("grant_id", 32'(grant_id), 32'(exp_gid));
        if (fifo_full) check("enq_while_full", 32'(fifo_enqueue), 32'd0);
        if (fifo_enqueue) begin
            if (exp_enq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_enqueue: got req_ready=%b data=%h, required no enqueue", req_ready, fifo_data_in);
            end else begin
                e = exp_enq.pop_front();
                check("grant_onehot", 32'(req_ready), 32'(1) << e.id);
                check("enq_data", fifo_data_in, e.data);
                exp_gid = e.id;
            end
        end
    end

    always @(negedge clk) begin : rd_mon
        if (fifo_dequeue) check("deq_while_empty", 32'(fifo_empty), 32'd0);
        if (out_valid && out_ready) begin
            if (exp_out.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_out: got out_data=%h, required no transfer", out_data);
            end else begin
                check("out_data", out_data, exp_out.pop_front());
            end
            xfer_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [31:0] d);
        pre_data = d;
        pre_req  = 1'b1;
        tick();
        pre_req  = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (exp_out.size() > 0 && k < budget) begin
            tick();
            k++;
        end
        check("drain", 32'(exp_out.size()), 32'd0);
    endtask

    task automatic wait_valid(input int budget);
        int k = 0;
        while (!out_valid && k < budget) begin
            tick();
            k++;
        end
        check("out_valid_wait", 32'(out_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int unsigned n0;
        reset      = 1'b1;
        req_valid  = 4'b0000;
        req_data   = {32'h00A3_0001, 32'h00A2_0001, 32'h00A1_0001, 32'h00A0_0001};
        force_full = 1'b0;
        pre_req    = 1'b0;
        pre_data   = '0;
        out_ready  = 1'b0;
        cur_time   = 16'hFFFF;
        #1;

        // Reset held with all requesters valid
        reset     = 1'b0;
        req_valid = 4'b1111;
        repeat (3) tick();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_enqueue", 32'(fifo_enqueue), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_dequeue", 32'(fifo_dequeue), 32'd0);

        // Round-robin over all four requesters: 0,1,2,3,0
        exp_enq.push_back('{0, 32'h00A0_0001});
        exp_enq.push_back('{1, 32'h00A1_0001});
        exp_enq.push_back('{2, 32'h00A2_0001});
        exp_enq.push_back('{3, 32'h00A3_0001});
        exp_enq.push_back('{0, 32'h00A0_0001});
        exp_out.push_back(32'h00A0_0001);
        exp_out.push_back(32'h00A1_0001);
        exp_out.push_back(32'h00A2_0001);
        exp_out.push_back(32'h00A3_0001);
        exp_out.push_back(32'h00A0_0001);
        reset     = 1'b1;
        out_ready = 1'b1;
        repeat (5) tick();
        req_valid = 4'b0000;
        check("rr_all_granted", 32'(exp_enq.size()), 32'd0);
        wait_drain(100);

        // Full back-pressure: requester 2 waits three cycles
        force_full = 1'b1;
        req_valid  = 4'b0100;
        repeat (3) tick();
        exp_enq.push_back('{2, 32'h00A2_0001});
        exp_out.push_back(32'h00A2_0001);
        force_full = 1'b0;
        tick();
        req_valid = 4'b0000;
        check("enq_after_full", 32'(exp_enq.size()), 32'd0);
        wait_drain(50);

        // Read throughput: three entries, one per two cycles, then idle
        exp_out.push_back(32'h000A_0001);
        exp_out.push_back(32'h000B_0001);
        exp_out.push_back(32'h000C_0001);
        n0 = xfer_cyc.size();
        preload(32'h000A_0001);
        preload(32'h000B_0001);
        preload(32'h000C_0001);
        begin
            int k = 0;
            while (xfer_cyc.size() < n0 + 3 && k < 40) begin
                tick();
                k++;
            end
        end
        check("rd_count", 32'(xfer_cyc.size() - n0), 32'd3);
        if (xfer_cyc.size() >= n0 + 3) begin
            check("rd_interval_1", xfer_cyc[n0+1] - xfer_cyc[n0], 32'd2);
            check("rd_interval_2", xfer_cyc[n0+2] - xfer_cyc[n0+1], 32'd2);
        end
        tick();
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("idle_dequeue", 32'(fifo_dequeue), 32'd0);

        // Consumer stall: entry held stable, no dequeue, then a single transfer
        out_ready = 1'b0;
        exp_out.push_back(32'h000C_0002);
        exp_out.push_back(32'h000D_0002);
        preload(32'h000C_0002);
        preload(32'h000D_0002);
        wait_valid(20);
        for (int i = 0; i < 5; i++) begin
            check("stall_data", out_data, 32'h000C_0002);
            check("stall_no_deq", 32'(fifo_dequeue), 32'd0);
            check("stall_valid", 32'(out_valid), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("single_xfer", 32'(exp_out.size()), 32'd1);
        check("after_xfer_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        wait_drain(50);

        // Timestamp gate
        out_ready = 1'b0;
        cur_time  = 16'd2;
        exp_out.push_back(32'h000B_0004);
        preload(32'h000B_0004);
        tick();
        check("gate_wait_valid", 32'(out_valid), 32'd0);
        tick();
`ifdef LT_GATE_EN
        check("gate_blocked", 32'(out_valid), 32'd0);
        cur_time = 16'd4;
        #1;
        check("gate_open", 32'(out_valid), 32'd1);
`else
        check("gate_ungated", 32'(out_valid), 32'd1);
`endif
        out_ready = 1'b1;
        wait_drain(20);
        cur_time = 16'hFFFF;

        // Reset while holding an entry: discarded, then lowest-index first grant
        out_ready = 1'b0;
        exp_out.push_back(32'h0055_0009);
        preload(32'h0055_0009);
        wait_valid(20);
        reset     = 1'b0;
        req_valid = 4'b1111;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", out_data, 32'd0);
        check("midrst_dequeue", 32'(fifo_dequeue), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        void'(exp_out.pop_back());
        tick();
        exp_enq.push_back('{2, 32'h00A2_0001});
        exp_out.push_back(32'h00A2_0001);
        reset     = 1'b1;
        req_valid = 4'b1100;
        out_ready = 1'b1;
        tick();
        req_valid = 4'b0000;
        check("post_rst_grant", 32'(exp_enq.size()), 32'd0);
        wait_drain(30);
        repeat (3) tick();
        check("final_enq_queue", 32'(exp_enq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
